// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor (diff = a - b mod 2^WIDTH).
// A single full-subtractor cell and a borrow flip-flop process one bit per clock.
// A start/busy/done handshake sequences each operation.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             bin_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             load_s;
    logic             shift_s;
    logic             last_s;
    logic [1:0]       cell_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE; start is only honoured in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/control decode: operand load, per-bit shift and final-bit strobes.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_RUN: begin
                shift_s = 1'b1;
                if (cnt_r == CW'(WIDTH - 1)) begin
                    last_s = 1'b1;
                end else begin
                    last_s = 1'b0;
                end
            end
            default: begin
                load_s  = 1'b0;
                shift_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // Current bit: LSBs of the operand shifters plus the stored borrow.
    always_comb begin
        cell_s = full_sub(a_sh_r[0], b_sh_r[0], bin_r);
    end

    // Datapath: operand shifters, borrow FF, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            bin_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else if (load_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            bin_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else if (shift_s) begin
            a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            diff_r <= {cell_s[0], diff_r[WIDTH-1:1]};
            bin_r  <= cell_s[1];
            cnt_r  <= cnt_r + CW'(1);
            if (last_s) begin
                busy_r   <= 1'b0;
                done_r   <= 1'b1;
                borrow_r <= cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
                // bin_r is the borrow into the MSB cell, cell_s[1] the borrow out of it.
                ovf_r    <= bin_r ^ cell_s[1];
`endif
            end else begin
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_r;
`endif

endmodule
